// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: op codes, FSM states,
// ALU function constants and flag bit positions.
package alu_seq_pkg;

    localparam int DATA_W = 32;
    localparam int MUL_W  = 16;

    localparam logic [1:0] OP_SINGLE = 2'b00;
    localparam logic [1:0] OP_REPEAT = 2'b01;
    localparam logic [1:0] OP_MUL    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Where the response flags come from once the command has finished.
    typedef enum logic [1:0] {
        FLG_ZERO = 2'd0,
        FLG_ALU  = 2'd1,
        FLG_MUL  = 2'd2
    } flag_src_e;

    localparam logic [4:0] FS_PASS_A32  = 5'h10;
    localparam logic [4:0] FS_ADD32     = 5'h14;
    localparam logic [3:0] FS_SHIFT_MIN = 4'hB;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    function automatic logic is_shift_fs(input logic [4:0] fs);
        return fs[3:0] >= FS_SHIFT_MIN;
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Multi-cycle command sequencer driving an external 32-bit ALU: SINGLE,
// REPEAT (shift/rotate iterations) and 16x16 shift-add MUL.
module alu_op_sequencer
    import alu_seq_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [1:0]          cmd_op_i,
    input  logic [4:0]          cmd_funsel_i,
    input  logic [DATA_W-1:0]   cmd_a_i,
    input  logic [DATA_W-1:0]   cmd_b_i,
    input  logic [4:0]          cmd_count_i,
    output logic [DATA_W-1:0]   alu_a_o,
    output logic [DATA_W-1:0]   alu_b_o,
    output logic [4:0]          alu_funsel_o,
    output logic                alu_wf_o,
    input  logic [DATA_W-1:0]   alu_out_i,
    input  logic [3:0]          alu_flags_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_data_o,
    output logic [3:0]          rsp_flags_o,
    output logic                rsp_err_o,
    output logic                busy_o
);

    state_e              state_q, state_d;
    flag_src_e           fsrc_q, fsrc_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   m_q, m_d;
    logic [MUL_W-1:0]    q_q, q_d;
    logic [1:0]          op_q, op_d;
    logic [4:0]          fs_q, fs_d;
    logic                err_q, err_d;
    logic                cmd_bad;

    assign cmd_bad = (cmd_op_i == 2'b11) ||
                     ((cmd_op_i == OP_REPEAT) && !is_shift_fs(cmd_funsel_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            fsrc_q  <= FLG_ZERO;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            op_q    <= OP_SINGLE;
            fs_q    <= FS_PASS_A32;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fsrc_q  <= fsrc_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            q_q     <= q_d;
            op_q    <= op_d;
            fs_q    <= fs_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fsrc_d       = fsrc_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        m_d          = m_q;
        q_d          = q_q;
        op_d         = op_q;
        fs_d         = fs_q;
        err_d        = err_q;
        cmd_ready_o  = 1'b0;
        rsp_valid_o  = 1'b0;
        alu_a_o      = '0;
        alu_b_o      = '0;
        alu_funsel_o = FS_PASS_A32;
        alu_wf_o     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    op_d    = cmd_op_i;
                    fs_d    = cmd_funsel_i;
                    err_d   = 1'b0;
                    fsrc_d  = FLG_ALU;
                    acc_d   = cmd_a_i;
                    m_d     = cmd_b_i;
                    q_d     = '0;
                    state_d = ST_EXEC;
                    if (cmd_bad) begin
                        // Illegal commands skip the ALU entirely.
                        acc_d   = '0;
                        m_d     = '0;
                        err_d   = 1'b1;
                        fsrc_d  = FLG_ZERO;
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else if (cmd_op_i == OP_SINGLE) begin
                        cnt_d = 5'd1;
                    end else if (cmd_op_i == OP_REPEAT) begin
                        m_d   = '0;
                        cnt_d = cmd_count_i;
                        if (cmd_count_i == 5'd0) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        acc_d  = '0;
                        m_d    = {{(DATA_W-MUL_W){1'b0}}, cmd_a_i[MUL_W-1:0]};
                        q_d    = cmd_b_i[MUL_W-1:0];
                        cnt_d  = 5'd16;
                        fsrc_d = FLG_MUL;
                    end
                end
            end

            ST_EXEC: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = ST_DONE;
                end
                if (op_q == OP_MUL) begin
                    m_d = m_q << 1;
                    q_d = q_q >> 1;
                    if (q_q[0]) begin
                        alu_a_o      = acc_q;
                        alu_b_o      = m_q;
                        alu_funsel_o = FS_ADD32;
                        acc_d        = alu_out_i;
                    end
                end else begin
                    // SINGLE uses m_q as B; REPEAT cleared it to zero.
                    alu_a_o      = acc_q;
                    alu_b_o      = m_q;
                    alu_funsel_o = fs_q;
                    alu_wf_o     = 1'b1;
                    acc_d        = alu_out_i;
                end
            end

            ST_DONE: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rsp_flags_o = 4'b0000;
        if (state_q == ST_DONE) begin
            case (fsrc_q)
                FLG_ALU: rsp_flags_o = alu_flags_i;
                FLG_MUL: begin
                    rsp_flags_o[FLAG_Z] = (acc_q == '0);
                    rsp_flags_o[FLAG_N] = acc_q[DATA_W-1];
                end
                default: rsp_flags_o = 4'b0000;
            endcase
        end
    end

    assign rsp_data_o = (state_q == ST_DONE) ? acc_q : '0;
    assign rsp_err_o  = (state_q == ST_DONE) && err_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural ALU and flag register
// standing in for the real ALU one level up.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_funsel;
    logic [31:0] cmd_a, cmd_b;
    logic [4:0]  cmd_count;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [4:0]  alu_funsel;
    logic        alu_wf;
    logic [3:0]  alu_flags = 4'b0000;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic        rsp_err, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_funsel_i (cmd_funsel),
        .cmd_a_i      (cmd_a),
        .cmd_b_i      (cmd_b),
        .cmd_count_i  (cmd_count),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_funsel_o (alu_funsel),
        .alu_wf_o     (alu_wf),
        .alu_out_i    (alu_out),
        .alu_flags_i  (alu_flags),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .rsp_flags_o  (rsp_flags),
        .rsp_err_o    (rsp_err),
        .busy_o       (busy)
    );

    // Behavioural ALU: pass, add, shift left, shift right; flags {Z,C,N,O}.
    logic alu_c, alu_v;
    always_comb begin
        alu_out = alu_a;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (alu_funsel)
            5'h14: begin
                {alu_c, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
                alu_v = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
            end
            5'h1B: begin
                alu_out = alu_a << 1;
                alu_c   = alu_a[31];
            end
            5'h1C: begin
                alu_out = alu_a >> 1;
                alu_c   = alu_a[0];
            end
            default: alu_out = alu_a;
        endcase
    end

    always @(posedge clk) begin
        if (alu_wf) alu_flags <= {alu_out == 32'd0, alu_c, alu_out[31], alu_v};
    end

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  fs;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  cnt;
        logic [31:0] exp_data;
        logic [3:0]  exp_flags;
        logic [3:0]  flag_mask;
        logic        exp_err;
        int          exp_lat;
        int          exp_wf;
        int          exp_act;
    } vec_t;

    vec_t vecs [10];

    logic [31:0] r_data;
    logic [3:0]  r_flags;
    logic        r_err;
    int          r_lat, r_wf, r_act;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] fs, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] cnt);
        @(negedge clk);
        cmd_op = op; cmd_funsel = fs; cmd_a = a; cmd_b = b; cmd_count = cnt;
        cmd_valid = 1'b1;
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Called just after the accept edge; waits for the response, optionally consumes it.
    task automatic collect(input bit consume);
        r_lat = 1; r_wf = 0; r_act = 0;
        forever begin
            @(negedge clk);
            if (alu_wf) r_wf++;
            if (alu_funsel != 5'h10) r_act++;
            if (rsp_valid) break;
            r_lat++;
            if (r_lat > 200) begin
                chk("rsp_timeout", 32'd1, 32'd0);
                break;
            end
        end
        r_data = rsp_data; r_flags = rsp_flags; r_err = rsp_err;
        if (consume) begin
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
    endtask

    initial begin
        //        op     fs     a             b             cnt    data          flags    mask     err   lat wf  act
        vecs[0] = '{2'b00, 5'h14, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 4'b0011, 4'b1111, 1'b0, 2,  1,  1};
        vecs[1] = '{2'b01, 5'h1B, 32'h00000001, 32'h0,        5'd31, 32'h80000000, 4'b0010, 4'b1010, 1'b0, 32, 31, 31};
        vecs[2] = '{2'b01, 5'h1B, 32'h00001234, 32'h0,        5'd0,  32'h00001234, 4'b0000, 4'b0000, 1'b0, 1,  0,  0};
        vecs[3] = '{2'b10, 5'h00, 32'h0000FFFF, 32'h0000FFFF, 5'd0,  32'hFFFE0001, 4'b0010, 4'b1111, 1'b0, 17, 0,  16};
        vecs[4] = '{2'b10, 5'h00, 32'h00001234, 32'h00000000, 5'd0,  32'h00000000, 4'b1000, 4'b1111, 1'b0, 17, 0,  0};
        vecs[5] = '{2'b11, 5'h14, 32'h12345678, 32'h11111111, 5'd3,  32'h00000000, 4'b0000, 4'b1111, 1'b1, 1,  0,  0};
        vecs[6] = '{2'b01, 5'h14, 32'h12345678, 32'h0,        5'd5,  32'h00000000, 4'b0000, 4'b1111, 1'b1, 1,  0,  0};
        vecs[7] = '{2'b10, 5'h00, 32'hABCD0003, 32'h99990005, 5'd0,  32'h0000000F, 4'b0000, 4'b1111, 1'b0, 17, 0,  2};
        vecs[8] = '{2'b00, 5'h14, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 4'b1100, 4'b1111, 1'b0, 2,  1,  1};
        vecs[9] = '{2'b01, 5'h1C, 32'h80000000, 32'h0,        5'd4,  32'h08000000, 4'b0000, 4'b1010, 1'b0, 5,  4,  4};

        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = 2'b00; cmd_funsel = 5'h0; cmd_a = '0; cmd_b = '0; cmd_count = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_flags", {28'd0, rsp_flags}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_funsel", {27'd0, alu_funsel}, 32'h10);
        chk("rst_alu_wf", {31'd0, alu_wf}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].fs, vecs[i].a, vecs[i].b, vecs[i].cnt);
            collect(1'b1);
            $display("vec %0d: op=%0d fs=%0h a=%0h b=%0h cnt=%0d -> data=%0h flags=%b err=%0d lat=%0d wf=%0d act=%0d",
                     i, vecs[i].op, vecs[i].fs, vecs[i].a, vecs[i].b, vecs[i].cnt,
                     r_data, r_flags, r_err, r_lat, r_wf, r_act);
            chk($sformatf("vec%0d_data", i), r_data, vecs[i].exp_data);
            chk($sformatf("vec%0d_flags", i), {28'd0, r_flags & vecs[i].flag_mask},
                {28'd0, vecs[i].exp_flags & vecs[i].flag_mask});
            chk($sformatf("vec%0d_err", i), {31'd0, r_err}, {31'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_latency", i), r_lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_wf_cycles", i), r_wf, vecs[i].exp_wf);
            chk($sformatf("vec%0d_alu_active", i), r_act, vecs[i].exp_act);
        end

        // Backpressure: response held five cycles while a new command waits.
        issue(2'b00, 5'h14, 32'd2, 32'd3, 5'd0);
        collect(1'b0);
        cmd_op = 2'b00; cmd_funsel = 5'h14; cmd_a = 32'd10; cmd_b = 32'd20; cmd_count = 5'd0;
        cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_data_stable", rsp_data, 32'd5);
            chk("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
            chk("bp_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
        end
        $display("backpressure: held response data=%0h", rsp_data);
        rsp_ready = 1'b1;
        chk("bp_cmd_ready_at_hs", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_cmd_ready_after_hs", {31'd0, cmd_ready}, 32'd1);
        chk("bp_rsp_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        collect(1'b1);
        $display("backpressure follow-up: data=%0h lat=%0d", r_data, r_lat);
        chk("bp_next_data", r_data, 32'd30);
        chk("bp_next_latency", r_lat, 2);

        // Reset in cycle 8 of a MUL, then a SINGLE must still work.
        issue(2'b10, 5'h00, 32'h0000FFFF, 32'h0000FFFF, 5'd0);
        repeat (8) @(negedge clk);
        chk("mul_busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_alu_wf", {31'd0, alu_wf}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        issue(2'b00, 5'h14, 32'h00000100, 32'h00000023, 5'd0);
        collect(1'b1);
        $display("post-reset single: data=%0h flags=%b lat=%0d", r_data, r_flags, r_lat);
        chk("postrst_data", r_data, 32'h00000123);
        chk("postrst_flags", {28'd0, r_flags}, 32'd0);
        chk("postrst_latency", r_lat, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
